dc_download_pp: RTL
===================

Name: dc_download_pp

Overview:
- Parametrised successor of the data-cache download reassembler.
- Collects reply flits from the IN fifo arbiter into message buffers and presents each complete message to the data cache.
- Two ping-pong slots: the next reply can be received while the cache is still consuming the previous one.
- Adds a message-length output, an in_ready backpressure signal and overflow detection.

Parameters:
- FLIT_W, 16, flit width in bits.
- MAX_FLITS, 9, flits stored per message (slot width = FLIT_W*MAX_FLITS).
- CMD_LSB, 5, LSB of the 5-bit cmd field in the header flit.
- CNT_W, 4, width of the flit counter and length output; must satisfy 2^CNT_W > MAX_FLITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_flit  in  FLIT_W  flit from the IN fifos.
- v_in_flit  in  1  in_flit valid.
- in_flit_ctrl  in  2  flit ctrl; 2'b11 = tail.
- dc_done_access  in  1  cache has consumed the presented message.
- in_ready  out  1  a flit is accepted this cycle iff v_in_flit && in_ready.
- v_dc_download  out  1  complete message presented.
- dc_download_flits  out  FLIT_W*MAX_FLITS  flit k in bits [k*FLIT_W +: FLIT_W]; header is k=0; unused flits read 0.
- dc_download_len  out  CNT_W  number of stored flits in the presented message.
- dc_download_state  out  2  00 idle, 01 busy, 10 rdy, 11 full.
- err_overflow  out  1  sticky overflow flag; cleared only by rst.

Behaviour:
- Storage: 2 slots, each holding data, a count and a done bit. wr_sel selects the slot being filled, rd_sel the slot being presented. All state is registered.
- Reset: slot data = 0, counts = 0, done = 0, wr_sel = rd_sel = 0, err_overflow = 0.
  - Outputs after reset: in_ready = 1, v_dc_download = 0, dc_download_flits = 0, dc_download_len = 0, dc_download_state = 00.
  - rst mid-message discards all slots.
- in_ready = !done[wr_sel]. It is a pure register decode, with no combinational path from v_in_flit or dc_done_access.
- On an accepted flit, with cnt = count[wr_sel]:
  - if cnt < MAX_FLITS, store the flit at index cnt and set cnt+1;
  - otherwise discard the flit and set err_overflow.
- Header (cnt == 0):
  - cmd field in {nackrep 10101, SCflurep 11100, C2Cinvrep 11011} → single-flit message; the slot completes immediately, regardless of ctrl.
  - any other cmd → multi-flit message.
- Multi-flit message completes on the accepted flit with ctrl == 2'b11.
- On completion: done[wr_sel] <= 1 and wr_sel toggles at the same edge.
- Latency: v_dc_download rises the cycle after the completing flit's accept edge.
- Output side:
  - v_dc_download = done[rd_sel]; flits and len come from slot rd_sel.
  - dc_done_access while v_dc_download is high: clear that slot's data, count and done at the edge, and toggle rd_sel.
  - dc_done_access while v_dc_download is low is ignored.
- Order: messages are presented strictly in arrival order.
- Simultaneous events: completion into one slot and release of the other in the same cycle are both performed.
- Both slots done: in_ready = 0. After a release, in_ready = 1 from the next cycle.
- dc_download_state:
  - 11 when both slots are done;
  - 10 when exactly one is done;
  - 01 when none is done and count[wr_sel] != 0;
  - otherwise 00.
- Overflow: flits beyond MAX_FLITS are dropped, but the message still completes on its tail with len = MAX_FLITS.

Decomposition:
- Package dc_dl_pkg holds:
  - the reply cmd constants (wbrep 10000 through wbfail_rep 10111);
  - TAIL_CTRL = 2'b11;
  - the state encodings;
  - function is_single_flit_cmd().
- Sub-module dc_dl_slot (one instance per slot):
  - contents: data registers, count and done;
  - write-enable/index inputs and a clear input;
  - parametrised by FLIT_W, MAX_FLITS and CNT_W.
- The top holds the pointers, flags and output mux.

Test Plan:
- Single-flit header cmd 10101 (nackrep) → v_dc_download = 1 the next cycle, len = 1, flit0 = header; pulse done → slot cleared, state = 00.
- Header + 8 flits, tail ctrl = 11 on flit 9 → len = 9, all 9 words in order, state = 10.
- Two messages back-to-back with done held low → state = 11, in_ready = 0, third header stalls. Done → first message released and second presented; in_ready = 1 one cycle later.
- Done pulsed in the same cycle as the tail of the next message → release and completion both occur, order preserved.
- 11-flit message with MAX_FLITS = 9 → flits 10–11 dropped, len = 9, err_overflow = 1 and remains set.
- rst asserted after 4 flits of a message → all outputs return to reset values; a new header is accepted the cycle after rst deasserts.

Source files
------------

// File: rtl/dc_dl_pkg.sv
// Shared constants, state encodings and helpers for the data-cache download reassembler.
package dc_dl_pkg;

  localparam int unsigned CMD_W = 5;

  // Reply commands delivered to the data cache
  localparam logic [CMD_W-1:0] CMD_WBREP      = 5'b10000;
  localparam logic [CMD_W-1:0] CMD_C2H_INVREP = 5'b10001;
  localparam logic [CMD_W-1:0] CMD_FLUSHREP   = 5'b10010;
  localparam logic [CMD_W-1:0] CMD_ATFLUREP   = 5'b10011;
  localparam logic [CMD_W-1:0] CMD_SHREP      = 5'b10100;
  localparam logic [CMD_W-1:0] CMD_NACKREP    = 5'b10101;
  localparam logic [CMD_W-1:0] CMD_EXREP      = 5'b10110;
  localparam logic [CMD_W-1:0] CMD_WBFAIL_REP = 5'b10111;
  localparam logic [CMD_W-1:0] CMD_C2C_INVREP = 5'b11011;
  localparam logic [CMD_W-1:0] CMD_SCFLUREP   = 5'b11100;

  localparam logic [1:0] TAIL_CTRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RDY  = 2'b10,
    ST_FULL = 2'b11
  } dl_state_e;

  // Replies that carry no payload and complete on their header
  function automatic logic is_single_flit_cmd(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_NACKREP) || (cmd == CMD_SCFLUREP) || (cmd == CMD_C2C_INVREP);
  endfunction

endpackage

// File: rtl/dc_dl_slot.sv
// One message buffer: flit storage, stored-flit count and a completion flag.
module dc_dl_slot #(
  parameter int unsigned FLIT_W    = 16,
  parameter int unsigned MAX_FLITS = 9,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic [CNT_W-1:0]            i_idx,
  input  logic [FLIT_W-1:0]           i_wdata,
  input  logic                        i_set_done,
  input  logic                        i_clr,
  output logic [FLIT_W*MAX_FLITS-1:0] o_data,
  output logic [CNT_W-1:0]            o_cnt,
  output logic                        o_done
);

  logic [FLIT_W*MAX_FLITS-1:0] r_data;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_done;

  // Clear wins so a released slot always reads back as empty
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (i_we) begin
        for (int unsigned k = 0; k < MAX_FLITS; k++) begin
          if (i_idx == CNT_W'(k)) r_data[k*FLIT_W +: FLIT_W] <= i_wdata;
        end
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_set_done) r_done <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_cnt  = r_cnt;
  assign o_done = r_done;

endmodule

// File: rtl/dc_download_pp.sv
// Ping-pong reassembler: collects reply flits into two slots and presents them in order.
module dc_download_pp
  import dc_dl_pkg::*;
#(
  parameter int unsigned FLIT_W    = 16,
  parameter int unsigned MAX_FLITS = 9,
  parameter int unsigned CMD_LSB   = 5,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_W-1:0]           in_flit,
  input  logic                        v_in_flit,
  input  logic [1:0]                  in_flit_ctrl,
  input  logic                        dc_done_access,
  output logic                        in_ready,
  output logic                        v_dc_download,
  output logic [FLIT_W*MAX_FLITS-1:0] dc_download_flits,
  output logic [CNT_W-1:0]            dc_download_len,
  output logic [1:0]                  dc_download_state,
  output logic                        err_overflow
);

  localparam int unsigned SLOT_W = FLIT_W * MAX_FLITS;

  logic              r_wr_sel;
  logic              r_rd_sel;
  logic              r_err;
  logic [1:0]        w_we;
  logic [1:0]        w_set_done;
  logic [1:0]        w_clr;
  logic [1:0]        w_done;
  logic [SLOT_W-1:0] w_data [2];
  logic [CNT_W-1:0]  w_cnt  [2];
  logic [CNT_W-1:0]  w_cnt_wr;
  logic              w_accept;
  logic              w_room;
  logic              w_single;
  logic              w_complete;
  logic              w_release;
  dl_state_e         w_state;

  assign in_ready   = ~w_done[r_wr_sel];
  assign w_cnt_wr   = w_cnt[r_wr_sel];
  assign w_accept   = v_in_flit && in_ready;
  assign w_room     = (w_cnt_wr < CNT_W'(MAX_FLITS));
  assign w_single   = (w_cnt_wr == '0) && is_single_flit_cmd(in_flit[CMD_LSB +: CMD_W]);
  assign w_complete = w_accept && (w_single || (in_flit_ctrl == TAIL_CTRL));
  assign w_release  = dc_done_access && w_done[r_rd_sel];

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign w_we[s]       = w_accept && w_room && (r_wr_sel == 1'(s));
    assign w_set_done[s] = w_complete && (r_wr_sel == 1'(s));
    assign w_clr[s]      = w_release && (r_rd_sel == 1'(s));

    dc_dl_slot #(
      .FLIT_W    (FLIT_W),
      .MAX_FLITS (MAX_FLITS),
      .CNT_W     (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_we[s]),
      .i_idx      (w_cnt_wr),
      .i_wdata    (in_flit),
      .i_set_done (w_set_done[s]),
      .i_clr      (w_clr[s]),
      .o_data     (w_data[s]),
      .o_cnt      (w_cnt[s]),
      .o_done     (w_done[s])
    );
  end

  // Pointers advance on completion/release; overflow flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_complete) r_wr_sel <= ~r_wr_sel;
      if (w_release)  r_rd_sel <= ~r_rd_sel;
      if (w_accept && !w_room) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state = ST_IDLE;
    if (&w_done)              w_state = ST_FULL;
    else if (|w_done)         w_state = ST_RDY;
    else if (w_cnt_wr != '0)  w_state = ST_BUSY;
  end

  assign v_dc_download     = w_done[r_rd_sel];
  assign dc_download_flits = w_data[r_rd_sel];
  assign dc_download_len   = w_cnt[r_rd_sel];
  assign dc_download_state = w_state;
  assign err_overflow      = r_err;

endmodule
